// File: rtl/pipeline_sched.sv
// Round-robin issue scheduler for the shared A1*B1 + A2*B2 datapath.
// Tags each issue with its requester and routes the result back LAT+1 cycles later.
module pipeline_sched #(
  parameter int W   = 32,
  parameter int LAT = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  input  logic [4*W-1:0] req0_ops,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [4*W-1:0] req1_ops,
  output logic           req1_ready,
  input  logic           drain,
  output logic [W-1:0]   pipe_A1,
  output logic [W-1:0]   pipe_A2,
  output logic [W-1:0]   pipe_B1,
  output logic [W-1:0]   pipe_B2,
  input  logic [W-1:0]   pipe_C,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [W-1:0]   rsp_data,
  output logic           busy
);

  logic           last_grant;
  logic [LAT:0]   tag_v;
  logic [LAT:0]   tag_id;
  logic           xfer;
  logic           xfer_id;
  logic [4*W-1:0] sel_ops;

  // last_grant==1 means requester 1 was served last, so requester 0 wins a tie
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!drain) begin
      if (req0_valid && (!req1_valid || last_grant))
        req0_ready = 1'b1;
      else if (req1_valid)
        req1_ready = 1'b1;
    end
  end

  assign xfer    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign xfer_id = req1_ready;
  assign sel_ops = req1_ready ? req1_ops : req0_ops;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      pipe_A1    <= '0;
      pipe_A2    <= '0;
      pipe_B1    <= '0;
      pipe_B2    <= '0;
      tag_v      <= '0;
      tag_id     <= '0;
    end else begin
      if (xfer)
        last_grant <= xfer_id;
      if (xfer) begin
        pipe_A1 <= sel_ops[4*W-1:3*W];
        pipe_A2 <= sel_ops[3*W-1:2*W];
        pipe_B1 <= sel_ops[2*W-1:W];
        pipe_B2 <= sel_ops[W-1:0];
      end else begin
        pipe_A1 <= '0;
        pipe_A2 <= '0;
        pipe_B1 <= '0;
        pipe_B2 <= '0;
      end
      tag_v  <= {tag_v[LAT-1:0], xfer};
      tag_id <= {tag_id[LAT-1:0], xfer & xfer_id};
    end
  end

  assign rsp0_valid = tag_v[LAT] & ~tag_id[LAT];
  assign rsp1_valid = tag_v[LAT] &  tag_id[LAT];
  assign rsp_data   = pipe_C;
  assign busy       = |tag_v;

endmodule

// File: doc/pipeline_sched.md
# pipeline_sched

Issue scheduler and response router for the two-operand-pair `pipeline` datapath, which computes `C = A1*B1 + A2*B2`. It shares the single fully pipelined datapath between two requesters using round-robin arbitration. Each cycle it issues at most one operand set and tags it with the requester ID. When the result emerges from the pipeline it routes it back to the originating requester. It sits between the requesters and the `pipeline` instance and owns all of the datapath's operand inputs.

## Interface
Parameters:
- W, 32, operand/result width
- LAT, 3, datapath latency: operands present on pipe_* during cycle n produce pipe_C during cycle n+LAT (LAT ≥ 1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand set
- req0_ops  in  4W  requester 0 operands, {a1, a2, b1, b2} (a1 in MSBs)
- req0_ready  out  1  requester 0 granted this cycle
- req1_valid, req1_ops, req1_ready  same as requester 0
- drain  in  1  block new issues; in-flight work completes
- pipe_A1, pipe_A2, pipe_B1, pipe_B2  out  W each  registered operands to datapath
- pipe_C  in  W  datapath result
- rsp0_valid  out  1  rsp_data belongs to requester 0 this cycle
- rsp1_valid  out  1  rsp_data belongs to requester 1 this cycle
- rsp_data  out  W  equals pipe_C (combinational passthrough)
- busy  out  1  at least one issue in flight

## Operation
- Clock is `clk`; reset is synchronous and active-high on `reset`.
- Arbitration (combinational):
  - With `drain`=1, neither ready is asserted.
  - Otherwise, if exactly one valid is high, that requester gets ready.
  - If both are high, the requester other than `last_grant` gets ready.
  - At most one ready is high per cycle. Ready never depends on the requester's own ready.
- Transfer occurs on `reqX_valid && reqX_ready` at a rising edge. On transfer:
  - pipe_A1/A2/B1/B2 load the corresponding fields of reqX_ops.
  - `last_grant` is set to X.
  - Tag {1, X} enters stage 0 of the tag shift register.
- No transfer in a cycle: pipe_* load 0 and tag stage 0 loads {0, 0}.
- Tag shift register has LAT+1 stages and shifts every cycle unconditionally. Stage LAT drives the response:
  - rsp0_valid = stage valid && id==0.
  - rsp1_valid = stage valid && id==1.
- No backpressure on responses; a requester must accept rsp in the cycle it appears.
- busy = OR of all tag-stage valid bits.
- Requesters may change ops or drop valid freely while not granted. No valid-stability rule is enforced.

## Timing
- Reset values:
  - pipe_* = 0
  - all tag stages = {0, 0}
  - rsp0_valid = rsp1_valid = 0
  - busy = 0
  - `last_grant` = 1, so req0 wins the first contention.
- rsp_data follows pipe_C and is don't-care when both rsp valids are low.
- Latency: a transfer at edge t puts operands on pipe_* in cycle t+1. The response is valid in cycle t+1+LAT, i.e. LAT+1 cycles after the handshake.
- Throughput: one issue per cycle. Responses return in issue order, with gaps matching issue gaps.
- Contention under continuous dual-valid: grants strictly alternate.
- Simultaneous drain and valid: drain wins and no transfer occurs. Deasserting drain re-enables ready in the same cycle.
- Reset mid-operation:
  - All in-flight tags are discarded; no rsp valid is asserted from the next cycle on.
  - pipe_* go to 0.
  - A handshake in the reset cycle is ignored (no transfer).

## Test plan
- Single request, LAT=3: req0 in cycle 10 with a1=0, b1=1, a2=2, b2=3 → req0_ready=1 in cycle 10; pipe_A1=0, pipe_B1=1, pipe_A2=2, pipe_B2=3 in cycle 11; rsp0_valid=1 with rsp_data=6 in cycle 14 only; rsp1_valid stays 0; busy high cycles 11–14.
- Contention: both valid from the first cycle after reset, req0 ops {1,1,1,1}, req1 ops {2,2,2,2} → grants 0,1,0,1,…; responses alternate rsp0 (data 2) and rsp1 (data 8), each exactly 4 cycles after its grant.
- Back-to-back single requester: req1 valid for 4 consecutive cycles with a1 = 1, 2, 3, 4 (others a2=0, b1=1, b2=0) → ready each cycle; rsp1_valid high 4 consecutive cycles with data 1, 2, 3, 4.
- Drain: 2 issues in flight, then drain=1 with both valid high → both readys low; the 2 responses still arrive on schedule; busy falls the cycle after the last response; releasing drain grants on the same cycle.
- Reset mid-flight: issue req0 and req1 on consecutive cycles, assert reset in the next cycle for one cycle → no rsp valid afterwards; pipe_* = 0; busy = 0; the first post-reset contention grants req0.
